// File: rtl/tactile_frame_packer_if.sv
// Stream interface for tactile_frame_packer.
// Carries the correlator result words into the packer and the framed byte
// stream out of it. The slave modport is the packer's view; master is the
// environment (correlator source + host byte sink).
interface tactile_frame_packer_if #(
  parameter int ADC_CHANNELS = 16,
  parameter int DAC_CHANNELS = 16,
  parameter int OUT_BITS     = 32
);
  localparam int AB = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;
  localparam int DB = (DAC_CHANNELS > 1) ? $clog2(DAC_CHANNELS) : 1;

  // correlator result stream (no backpressure)
  logic                in_valid;
  logic [DB-1:0]       in_dac;
  logic [AB-1:0]       in_adc;
  logic                in_phase;
  logic [OUT_BITS-1:0] in_data;

  // packet byte stream toward the host
  logic [7:0]          m_data;
  logic                m_valid;
  logic                m_ready;

  modport slave (
    input  in_valid, in_dac, in_adc, in_phase, in_data,
    input  m_ready,
    output m_data, m_valid
  );

  modport master (
    output in_valid, in_dac, in_adc, in_phase, in_data,
    output m_ready,
    input  m_data, m_valid
  );
endinterface

// File: rtl/tactile_frame_packer.sv
// tactile_frame_packer: collects one I+Q correlation matrix per frame into a
// double-buffered RAM and serialises complete frames as
//   SYNC_HI SYNC_LO SEQ PAYLOAD... CSUM
// on a valid/ready byte stream. Frames completing while the serialiser is
// busy are dropped whole so the correlator never stalls.
// Optional macro TACTILE_PACK_TRUNC_EN: send only the top 16 bits of each
// word (2 bytes, little-endian) instead of the full OUT_BITS/8 bytes.
module tactile_frame_packer #(
  parameter int          ADC_CHANNELS = 16,
  parameter int          DAC_CHANNELS = 16,
  parameter int          OUT_BITS     = 32,
  parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
  input  logic                 clk,
  input  logic                 rst,
  tactile_frame_packer_if.slave bus,
  output logic                 busy,
  output logic [15:0]          drop_count,
  output logic [15:0]          resync_count
);
  localparam int AB    = (ADC_CHANNELS > 1) ? $clog2(ADC_CHANNELS) : 1;
  localparam int DB    = (DAC_CHANNELS > 1) ? $clog2(DAC_CHANNELS) : 1;
  localparam int AW    = 1 + AB + DB;
  localparam int DEPTH = 1 << AW;
  localparam int N     = 2 * ADC_CHANNELS * DAC_CHANNELS;
  localparam int CW    = $clog2(N + 1);
`ifdef TACTILE_PACK_TRUNC_EN
  localparam int PW    = 16;
`else
  localparam int PW    = OUT_BITS;
`endif
  localparam int BPW   = PW / 8;
  localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW-1:0] LAST_ADDR =
    {1'b1, AB'(ADC_CHANNELS - 1), DB'(DAC_CHANNELS - 1)};

  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, PAYLOAD, CSUM} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next word address in packet order: dac fastest, then adc, then phase.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    logic          p;
    logic [AB-1:0] c;
    logic [DB-1:0] d;
    {p, c, d} = a;
    if (d == DB'(DAC_CHANNELS - 1)) begin
      d = '0;
      if (c == AB'(ADC_CHANNELS - 1)) begin
        c = '0;
        p = ~p;
      end else begin
        c = c + 1'b1;
      end
    end else begin
      d = d + 1'b1;
    end
    return {p, c, d};
  endfunction

  // ---------------------------------------------------------------------
  // Frame tracking / write side
  // ---------------------------------------------------------------------
  logic [AW-1:0]       in_addr;
  logic                is_start, is_end;
  logic [CW-1:0]       cnt;
  logic                wr_en, done;
  logic [AW-1:0]       wr_addr;
  logic [OUT_BITS-1:0] wr_data;

  assign in_addr  = {bus.in_phase, bus.in_adc, bus.in_dac};
  assign is_start = (in_addr == '0);
  assign is_end   = (in_addr == LAST_ADDR);

  // Word counter: validates frame shape and stages the RAM write one cycle
  // later; done marks a good frame whose last word lands with the swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      wr_en        <= 1'b0;
      done         <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      resync_count <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (bus.in_valid) begin
        wr_addr <= in_addr;
        wr_data <= bus.in_data;
        if (is_start) begin
          cnt   <= CW'(1);
          wr_en <= 1'b1;
          if (cnt != '0) resync_count <= sat_inc(resync_count);
        end else if (cnt != '0) begin
          if (is_end) begin
            cnt   <= '0;
            wr_en <= 1'b1;
            if (cnt == CW'(N - 1)) done <= 1'b1;
            else                   resync_count <= sat_inc(resync_count);
          end else if (cnt == CW'(N - 1)) begin
            // N words seen without the end word: malformed frame
            cnt          <= '0;
            resync_count <= sat_inc(resync_count);
          end else begin
            cnt   <= cnt + 1'b1;
            wr_en <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Double-buffered frame RAM
  // ---------------------------------------------------------------------
  logic                wr_bank;
  logic [OUT_BITS-1:0] mem [2*DEPTH];
  logic [OUT_BITS-1:0] rd_q;
  logic [AW-1:0]       rd_ptr;

  // Write bank takes incoming words; the other bank is read continuously at
  // rd_ptr so rd_q always holds the prefetched next payload word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_q <= mem[{~wr_bank, rd_ptr}];
  end

  // ---------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------
  state_t         state, state_nxt;
  logic           adv, start;
  logic [7:0]     m_data_q, seq, csum, ld_byte;
  logic           ld, ld_word, shift, add_csum;
  logic [PW-1:0]  pw_rd, cur_word;
  logic [BIW-1:0] bidx;
  logic [AW-1:0]  widx;
  logic           last_byte, last_word;

`ifdef TACTILE_PACK_TRUNC_EN
  assign pw_rd = rd_q[OUT_BITS-1 -: 16];
`else
  assign pw_rd = rd_q;
`endif

  assign busy        = (state != IDLE);
  assign bus.m_valid = busy;
  assign bus.m_data  = m_data_q;
  assign adv         = bus.m_valid && bus.m_ready;
  // final CSUM handshake in the same cycle frees the serialiser for this frame
  assign start       = done && (state == IDLE || (state == CSUM && adv));
  assign last_byte   = (bidx == BIW'(BPW - 1));
  assign last_word   = (widx == LAST_ADDR);

  // Bank swap on an accepted frame; otherwise count the dropped frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      drop_count <= '0;
    end else if (done) begin
      if (start) wr_bank    <= ~wr_bank;
      else       drop_count <= sat_inc(drop_count);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: every advance is gated by a byte handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SYNC0;
      SYNC0:   if (adv) state_nxt = SYNC1;
      SYNC1:   if (adv) state_nxt = SEQ;
      SEQ:     if (adv) state_nxt = PAYLOAD;
      PAYLOAD: if (adv && last_byte && last_word) state_nxt = CSUM;
      CSUM:    if (adv) state_nxt = start ? SYNC0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: which byte is loaded into m_data on this edge.
  always_comb begin
    ld       = 1'b0;
    ld_word  = 1'b0;
    shift    = 1'b0;
    add_csum = 1'b0;
    ld_byte  = m_data_q;
    case (state)
      IDLE: if (start) begin
        ld      = 1'b1;
        ld_byte = SYNC_WORD[15:8];
      end
      SYNC0: if (adv) begin
        ld      = 1'b1;
        ld_byte = SYNC_WORD[7:0];
      end
      SYNC1: if (adv) begin
        ld       = 1'b1;
        add_csum = 1'b1;
        ld_byte  = seq;
      end
      SEQ: if (adv) begin
        ld       = 1'b1;
        ld_word  = 1'b1;
        add_csum = 1'b1;
        ld_byte  = pw_rd[7:0];
      end
      PAYLOAD: if (adv) begin
        ld = 1'b1;
        if (!last_byte) begin
          shift    = 1'b1;
          add_csum = 1'b1;
          ld_byte  = cur_word[7:0];
        end else if (last_word) begin
          ld_byte = csum;
        end else begin
          ld_word  = 1'b1;
          add_csum = 1'b1;
          ld_byte  = pw_rd[7:0];
        end
      end
      CSUM: if (start) begin
        ld      = 1'b1;
        ld_byte = SYNC_WORD[15:8];
      end
      default: ;
    endcase
  end

  // Byte datapath: m_data register, checksum, word shifter and the read
  // pointer, which runs one word ahead of the word being shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q <= '0;
      csum     <= '0;
      cur_word <= '0;
      bidx     <= '0;
      widx     <= '0;
      rd_ptr   <= '0;
      seq      <= '0;
    end else begin
      if (ld) m_data_q <= ld_byte;

      if (start)         csum <= '0;
      else if (add_csum) csum <= csum + ld_byte;

      if (start)        rd_ptr <= '0;
      else if (ld_word) rd_ptr <= next_addr(rd_ptr);

      if (ld_word) begin
        cur_word <= pw_rd >> 8;
        bidx     <= '0;
        widx     <= rd_ptr;
      end else if (shift) begin
        cur_word <= cur_word >> 8;
        bidx     <= bidx + 1'b1;
      end

      if (state == CSUM && adv) seq <= seq + 8'd1;
    end
  end
endmodule

// File: tb/tb_tactile_frame_packer.sv
// Self-checking bench for tactile_frame_packer (2x2 matrix, 32-bit words).
// Expected packet bytes are built from the words driven and queued; the
// monitor pops and compares on each byte handshake.
module tb_tactile_frame_packer;
  localparam int ADC = 2;
  localparam int DAC = 2;
  localparam int OB  = 32;
  localparam int NW  = 2 * ADC * DAC;
`ifdef TACTILE_PACK_TRUNC_EN
  localparam int BPW = 2;
`else
  localparam int BPW = 4;
`endif
  localparam int PKT = 4 + NW * BPW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [15:0] drop_count, resync_count;

  tactile_frame_packer_if #(.ADC_CHANNELS(ADC), .DAC_CHANNELS(DAC), .OUT_BITS(OB)) bus();

  tactile_frame_packer #(
    .ADC_CHANNELS(ADC), .DAC_CHANNELS(DAC), .OUT_BITS(OB), .SYNC_WORD(16'hA55A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .drop_count(drop_count),
    .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          hs_count = 0;
  int          ready_mode = 1;   // 0 low, 1 high, 2 random
  logic [7:0]  q[$];
  logic [7:0]  exp_seq = 8'd0;
  logic [31:0] frame_img [NW];

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [15:0] exp_resync;
    bit          frame;
  } rec_t;
  rec_t tbl [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int addr, input logic [31:0] data);
    logic [2:0] a;
    a = 3'(addr);
    bus.in_valid = 1'b1;
    bus.in_phase = a[2];
    bus.in_adc   = a[1];
    bus.in_dac   = a[0];
    bus.in_data  = data;
    frame_img[addr] = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_packet();
    logic [7:0]  cs;
    logic [31:0] w;
    cs = exp_seq;
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    q.push_back(exp_seq);
    for (int i = 0; i < NW; i++) begin
      w = frame_img[i];
`ifdef TACTILE_PACK_TRUNC_EN
      w = {16'h0, w[31:16]};
`endif
      for (int b = 0; b < BPW; b++) begin
        q.push_back(w[8*b +: 8]);
        cs = cs + w[8*b +: 8];
      end
    end
    q.push_back(cs);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic send_frame(input logic [31:0] mul, input logic [31:0] add, input bit expect_pkt);
    for (int i = 0; i < NW; i++) drive_word(i, mul * 32'(i + 1) + add);
    if (expect_pkt) push_packet();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || bus.m_valid) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    exp_seq = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // m_ready driver
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // byte monitor: scoreboard pop and stall-stability check
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        hs_count++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h with no byte expected", bus.m_data);
        end else begin
          check("pkt_byte", 32'(bus.m_data), 32'(q.pop_front()));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, tp, hs0, n;
    bit found;

    // word-counter vectors: {addr, data, resync after word, frame completes}
    tbl[0]  = '{0, 32'h11, 16'd0, 1'b0};
    tbl[1]  = '{1, 32'h12, 16'd0, 1'b0};
    tbl[2]  = '{2, 32'h13, 16'd0, 1'b0};
    tbl[3]  = '{3, 32'h14, 16'd0, 1'b0};
    tbl[4]  = '{0, 32'h21, 16'd1, 1'b0};   // restart mid-frame
    for (int i = 1; i < 8; i++) tbl[4+i] = '{i, 32'h21 + 32'(i), 16'd1, (i == 7)};
    tbl[12] = '{5, 32'h99, 16'd1, 1'b0};   // counter 0: ignored
    tbl[13] = '{7, 32'h98, 16'd1, 1'b0};   // end word with counter 0: ignored
    tbl[14] = '{0, 32'h31, 16'd1, 1'b0};
    tbl[15] = '{1, 32'h32, 16'd1, 1'b0};
    tbl[16] = '{2, 32'h33, 16'd1, 1'b0};
    tbl[17] = '{7, 32'h34, 16'd2, 1'b0};   // end word, wrong count
    tbl[18] = '{0, 32'h41, 16'd2, 1'b0};
    for (int i = 1; i < 7; i++) tbl[18+i] = '{i, 32'h41 + 32'(i), 16'd2, 1'b0};
    tbl[25] = '{1, 32'h48, 16'd3, 1'b0};   // would reach N without end word
    tbl[26] = '{3, 32'h49, 16'd3, 1'b0};   // counter 0: ignored

    bus.in_valid = 1'b0;
    bus.in_phase = 1'b0;
    bus.in_adc   = '0;
    bus.in_dac   = '0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_resync", 32'(resync_count), 32'd0);

    // nominal frame: latency and throughput
    ready_mode = 1;
    send_frame(32'h01020304, 32'd0, 1'b1);
    lat = 0;
    found = 1'b0;
    while (!found && lat < 3) begin
      @(negedge clk);
      lat++;
      if (bus.m_valid) found = 1'b1;
    end
    check("sync_latency", 32'(found), 32'd1);
    tp = 0;
    while (bus.m_valid && tp < 200) begin
      @(negedge clk);
      tp++;
    end
    check("throughput", 32'(tp <= 2 * PKT), 32'd1);
    wait_drain("nominal_drain");
    send_frame(32'h01020304, 32'h10, 1'b1);    // carries seq 01
    wait_drain("seq1_drain");

    // random backpressure
    ready_mode = 2;
    send_frame(32'h01020304, 32'd0, 1'b1);
    wait_drain("backpressure_drain");
    ready_mode = 1;

    // overrun: second frame dropped while the first is stalled
    apply_reset();
    ready_mode = 0;
    tick();
    tick();
    send_frame(32'h11111111, 32'd0, 1'b1);
    repeat (4) tick();
    check("ovr_busy", 32'(busy), 32'd1);
    check("ovr_hold_data", 32'(bus.m_data), 32'hA5);
    send_frame(32'h22222222, 32'd5, 1'b0);
    repeat (3) tick();
    check("ovr_drop", 32'(drop_count), 32'd1);
    check("ovr_resync", 32'(resync_count), 32'd0);
    ready_mode = 1;
    wait_drain("ovr_first_drain");
    send_frame(32'h0, 32'hAABBCCDD, 1'b1);     // seq 01
    wait_drain("ovr_third_drain");
    check("ovr_drop_after", 32'(drop_count), 32'd1);

    // resync vectors
    apply_reset();
    for (int i = 0; i < 27; i++) begin
      drive_word(tbl[i].addr, tbl[i].data);
      @(negedge clk);
      check($sformatf("resync_tbl[%0d]", i), 32'(resync_count), 32'(tbl[i].exp_resync));
      if (tbl[i].frame) push_packet();
    end
    wait_drain("resync_drain");
    check("resync_drop", 32'(drop_count), 32'd0);

    // reset mid-packet after the 10th byte
    ready_mode = 1;
    send_frame(32'h03030303, 32'd1, 1'b1);
    hs0 = hs_count;
    n = 0;
    while ((hs_count - hs0) < 10 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midrst_reach10", 32'(hs_count - hs0), 32'd10);
    @(posedge clk);
    #2;
    check("midrst_before", 32'(bus.m_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    check("midrst_resync", 32'(resync_count), 32'd0);
    q.delete();
    exp_seq = 8'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_frame(32'h05050505, 32'd7, 1'b1);     // seq 00 again
    wait_drain("midrst_next_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
